// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;
  localparam int NUM_REQ = 2;
  localparam int CORE_IX = 0;
  localparam int HOST_IX = 1;

  typedef enum logic {SHARED, HOST_LOCKED} arb_state_t;
  typedef enum logic {REQ_CORE, REQ_HOST} req_id_t;

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/dmem_arbiter_rd_ret.sv
// Per-requester read return: captures memory data on a granted read and
// raises rvalid for the following cycle only.
module arb_rd_ret #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          rd_fire,
  input  logic [DW-1:0] m_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = rd_fire;
    rdata_d  = rd_fire ? m_rdata : rdata_q;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory: round-robin, optional
// host lock with burst/wait bounds. DMEM_ARB_STATS_EN adds grant counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = DMEM_AW,
  parameter int DW         = DMEM_DW,
  parameter int HOST_BURST = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic          h_lock,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          stall
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   c_gnt_ct,
  output logic [15:0]   h_gnt_ct
`endif
);
  localparam int BW = cnt_w(HOST_BURST);
  localparam int WW = cnt_w(MAX_WAIT);
  localparam logic [BW-1:0] BURST_MAX = BW'(HOST_BURST);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

  arb_state_t    state_q, state_d;
  req_id_t       last_q, last_d;
  logic [BW-1:0] burst_ct_q, burst_ct_d;
  logic [WW-1:0] wait_ct_q, wait_ct_d;
  logic          c_win, h_win, force_core;

  always_comb begin
    c_win      = 1'b0;
    h_win      = 1'b0;
    force_core = c_req && (burst_ct_q == BURST_MAX || wait_ct_q == WAIT_MAX);
    case (state_q)
      SHARED: begin
        if (c_req && h_req) begin
          c_win = (last_q == REQ_HOST);
          h_win = (last_q == REQ_CORE);
        end else begin
          c_win = c_req;
          h_win = h_req;
        end
      end
      HOST_LOCKED: begin
        if (force_core)  c_win = 1'b1;
        else if (h_req)  h_win = 1'b1;
        else             c_win = c_req;
      end
      default: ;
    endcase
  end

  // Grants are held off while reset is asserted so no write can slip out.
  assign c_gnt = c_win & Reset_n;
  assign h_gnt = h_win & Reset_n;
  assign stall = c_req & ~c_gnt;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    burst_ct_d = burst_ct_q;
    wait_ct_d  = wait_ct_q;
    if (c_gnt)      last_d = REQ_CORE;
    else if (h_gnt) last_d = REQ_HOST;
    if (c_gnt)
      wait_ct_d = '0;
    else if (stall && wait_ct_q != WAIT_MAX)
      wait_ct_d = wait_ct_q + WW'(1);
    case (state_q)
      SHARED: begin
        if (h_gnt && h_lock) begin
          state_d    = HOST_LOCKED;
          burst_ct_d = BW'(1);
        end
      end
      HOST_LOCKED: begin
        if (c_gnt)
          burst_ct_d = '0;
        else if (h_gnt && burst_ct_q != BURST_MAX)
          burst_ct_d = burst_ct_q + BW'(1);
        // A grant issued this cycle still completes; only the state drops.
        if (!h_lock) begin
          state_d    = SHARED;
          burst_ct_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= SHARED;
      last_q     <= REQ_HOST;
      burst_ct_q <= '0;
      wait_ct_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      burst_ct_q <= burst_ct_d;
      wait_ct_q  <= wait_ct_d;
    end
  end

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (h_gnt) begin
      m_we    = h_we;
      m_addr  = h_addr;
      m_wdata = h_wdata;
    end
  end

  logic [NUM_REQ-1:0]         rd_fire, rvalid;
  logic [NUM_REQ-1:0][DW-1:0] rdata;

  assign rd_fire[CORE_IX] = c_gnt & ~c_we;
  assign rd_fire[HOST_IX] = h_gnt & ~h_we;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rd
    arb_rd_ret #(.DW(DW)) u_rd_ret (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .rd_fire (rd_fire[i]),
      .m_rdata (m_rdata),
      .rvalid  (rvalid[i]),
      .rdata   (rdata[i])
    );
  end

  assign c_rvalid = rvalid[CORE_IX];
  assign c_rdata  = rdata[CORE_IX];
  assign h_rvalid = rvalid[HOST_IX];
  assign h_rdata  = rdata[HOST_IX];

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] c_gnt_ct_q, c_gnt_ct_d, h_gnt_ct_q, h_gnt_ct_d;

  always_comb begin
    c_gnt_ct_d = c_gnt_ct_q;
    h_gnt_ct_d = h_gnt_ct_q;
    if (c_gnt && c_gnt_ct_q != 16'hFFFF) c_gnt_ct_d = c_gnt_ct_q + 16'd1;
    if (h_gnt && h_gnt_ct_q != 16'hFFFF) h_gnt_ct_d = h_gnt_ct_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      c_gnt_ct_q <= '0;
      h_gnt_ct_q <= '0;
    end else begin
      c_gnt_ct_q <= c_gnt_ct_d;
      h_gnt_ct_q <= h_gnt_ct_d;
    end
  end

  assign c_gnt_ct = c_gnt_ct_q;
  assign h_gnt_ct = h_gnt_ct_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          Reset_n = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic          c_gnt, c_rvalid, h_gnt, h_rvalid, m_we, stall;
  logic [DW-1:0] c_rdata, h_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   c_gnt_ct, h_gnt_ct;
`endif

  logic [DW-1:0] mem [256];
  int n_chk = 0;
  int n_pass = 0;
  int rst_we_ct = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .HOST_BURST(16), .MAX_WAIT(4)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stall(stall)
`ifdef DMEM_ARB_STATS_EN
    , .c_gnt_ct(c_gnt_ct), .h_gnt_ct(h_gnt_ct)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (m_we) mem[m_addr] <= m_wdata;
  always @(posedge CLK) if (!Reset_n && m_we) rst_we_ct <= rst_we_ct + 1;
  assign m_rdata = mem[m_addr];

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_lock = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    Reset_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    Reset_n = 1'b0;
    @(negedge CLK);
    n_chk++; if ({c_gnt, h_gnt, c_rvalid, h_rvalid, m_we, stall} !== 6'b0)
      $display("FAIL rst_flags: got %b want 000000", {c_gnt, h_gnt, c_rvalid, h_rvalid, m_we, stall}); else n_pass++;
    n_chk++; if (c_rdata !== 8'h00 || h_rdata !== 8'h00 || m_addr !== 8'h00 || m_wdata !== 8'h00)
      $display("FAIL rst_data: got c_rdata=%h h_rdata=%h m_addr=%h m_wdata=%h want all 00", c_rdata, h_rdata, m_addr, m_wdata); else n_pass++;
    c_req = 1'b1; h_req = 1'b1; h_we = 1'b1; h_wdata = 8'h77;
    @(negedge CLK);
    n_chk++; if ({c_gnt, h_gnt, m_we} !== 3'b000)
      $display("FAIL rst_gnt_forced: got c_gnt,h_gnt,m_we=%b want 000", {c_gnt, h_gnt, m_we}); else n_pass++;
    cyc();
    idle();
    Reset_n = 1'b1;
    @(negedge CLK);
    n_chk++; if ({c_gnt, h_gnt, c_rvalid, h_rvalid, stall} !== 5'b0)
      $display("FAIL post_rst_idle: got %b want 00000", {c_gnt, h_gnt, c_rvalid, h_rvalid, stall}); else n_pass++;
    cyc();
  endtask

  task automatic test_core_only();
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'd9; c_wdata = 8'hA5;
    @(negedge CLK);
    n_chk++; if (c_gnt !== 1'b1 || stall !== 1'b0)
      $display("FAIL core_wr_gnt: got gnt=%b stall=%b want 1 0", c_gnt, stall); else n_pass++;
    n_chk++; if (m_we !== 1'b1 || m_addr !== 8'd9 || m_wdata !== 8'hA5)
      $display("FAIL core_wr_mem: got we=%b addr=%0d data=%h want 1 9 a5", m_we, m_addr, m_wdata); else n_pass++;
    cyc();
    c_we = 1'b0;
    @(negedge CLK);
    n_chk++; if (c_gnt !== 1'b1 || stall !== 1'b0 || c_rvalid !== 1'b0)
      $display("FAIL core_rd_gnt: got gnt=%b stall=%b rvalid=%b want 1 0 0", c_gnt, stall, c_rvalid); else n_pass++;
    cyc();
    c_req = 1'b0;
    @(negedge CLK);
    n_chk++; if (c_rvalid !== 1'b1 || c_rdata !== 8'hA5)
      $display("FAIL core_rd_data: got rvalid=%b rdata=%h want 1 a5", c_rvalid, c_rdata); else n_pass++;
    cyc();
    @(negedge CLK);
    n_chk++; if (c_rvalid !== 1'b0 || c_rdata !== 8'hA5)
      $display("FAIL core_rd_hold: got rvalid=%b rdata=%h want 0 a5", c_rvalid, c_rdata); else n_pass++;
    cyc();
    idle();
  endtask

  task automatic test_contention();
    do_reset();
    c_req = 1'b1; c_addr = 8'd9; h_req = 1'b1; h_addr = 8'd10;
    for (int i = 0; i < 6; i++) begin
      logic exp_c;
      exp_c = (i % 2 == 0);
      @(negedge CLK);
      n_chk++; if (c_gnt !== exp_c || h_gnt !== !exp_c || stall !== !exp_c)
        $display("FAIL rr_cycle%0d: got c_gnt=%b h_gnt=%b stall=%b want %b %b %b",
                 i, c_gnt, h_gnt, stall, exp_c, !exp_c, !exp_c); else n_pass++;
      cyc();
    end
    idle();
  endtask

  task automatic test_host_lock();
    int hcnt, cyc_n, streak, maxstreak, cg, both;
    hcnt = 0; cyc_n = 0; streak = 0; maxstreak = 0; cg = 0; both = 0;
    do_reset();
    h_req = 1'b1; h_lock = 1'b1; h_we = 1'b1; h_addr = 8'd32; h_wdata = 8'd32 ^ 8'h5A;
    while (hcnt < 64 && cyc_n < 400) begin
      c_req = (cyc_n >= 3); c_we = 1'b0; c_addr = 8'd9;
      @(negedge CLK);
      if (c_gnt && h_gnt) both++;
      if (c_gnt) cg++;
      if (stall) begin
        streak++;
        if (streak > maxstreak) maxstreak = streak;
      end else streak = 0;
      if (h_gnt) hcnt++;
      cyc();
      cyc_n++;
      h_addr  = 8'(32 + hcnt);
      h_wdata = 8'(32 + hcnt) ^ 8'h5A;
    end
    idle();
    n_chk++; if (hcnt !== 64 || cyc_n !== 79)
      $display("FAIL lock_host_writes: got %0d writes in %0d cycles want 64 in 79", hcnt, cyc_n); else n_pass++;
    n_chk++; if (cg !== 15)
      $display("FAIL lock_core_grants: got %0d want 15", cg); else n_pass++;
    n_chk++; if (maxstreak !== 4)
      $display("FAIL lock_max_stall: got %0d want 4", maxstreak); else n_pass++;
    n_chk++; if (both !== 0)
      $display("FAIL lock_dual_gnt: got %0d cycles want 0", both); else n_pass++;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] exp_d;
      exp_d = 8'(32 + i) ^ 8'h5A;
      h_req = 1'b1; h_we = 1'b0; h_addr = 8'(32 + i);
      cyc();
      h_req = 1'b0;
      @(negedge CLK);
      n_chk++; if (h_rvalid !== 1'b1 || h_rdata !== exp_d)
        $display("FAIL readback_%0d: got rvalid=%b rdata=%h want 1 %h", 32 + i, h_rvalid, h_rdata, exp_d); else n_pass++;
      cyc();
    end
    idle();
  endtask

  task automatic test_lock_release();
    do_reset();
    h_req = 1'b1; h_lock = 1'b1; h_we = 1'b1; h_addr = 8'd100; h_wdata = 8'h11;
    @(negedge CLK);
    n_chk++; if (h_gnt !== 1'b1)
      $display("FAIL rel_first_gnt: got %b want 1", h_gnt); else n_pass++;
    cyc();
    h_addr = 8'd101; h_wdata = 8'h22; h_lock = 1'b0;
    c_req = 1'b1; c_addr = 8'd9;
    @(negedge CLK);
    n_chk++; if (h_gnt !== 1'b1 || c_gnt !== 1'b0)
      $display("FAIL rel_drop_gnt: got h_gnt=%b c_gnt=%b want 1 0", h_gnt, c_gnt); else n_pass++;
    cyc();
    h_we = 1'b0; h_addr = 8'd100;
    @(negedge CLK);
    n_chk++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0)
      $display("FAIL rel_rr_core: got c_gnt=%b h_gnt=%b want 1 0", c_gnt, h_gnt); else n_pass++;
    cyc();
    @(negedge CLK);
    n_chk++; if (c_gnt !== 1'b0 || h_gnt !== 1'b1)
      $display("FAIL rel_rr_host: got c_gnt=%b h_gnt=%b want 0 1", c_gnt, h_gnt); else n_pass++;
    cyc();
    idle();
    n_chk++; if (mem[100] !== 8'h11 || mem[101] !== 8'h22)
      $display("FAIL rel_mem: got %h %h want 11 22", mem[100], mem[101]); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'd50; h_wdata = 8'h3C;
    cyc();
    h_we = 1'b0; h_lock = 1'b1;
    @(negedge CLK);
    n_chk++; if (h_gnt !== 1'b1)
      $display("FAIL mid_rd_gnt: got %b want 1", h_gnt); else n_pass++;
    cyc();
    n_chk++; if (h_rvalid !== 1'b1 || h_rdata !== 8'h3C)
      $display("FAIL mid_rd_pre: got rvalid=%b rdata=%h want 1 3c", h_rvalid, h_rdata); else n_pass++;
    Reset_n = 1'b0; h_we = 1'b1; h_wdata = 8'hFF;
    @(negedge CLK);
    n_chk++; if (h_rvalid !== 1'b0 || h_rdata !== 8'h00)
      $display("FAIL mid_rd_drop: got rvalid=%b rdata=%h want 0 00", h_rvalid, h_rdata); else n_pass++;
    n_chk++; if (h_gnt !== 1'b0 || m_we !== 1'b0)
      $display("FAIL mid_rd_nogrant: got h_gnt=%b m_we=%b want 0 0", h_gnt, m_we); else n_pass++;
    cyc();
    Reset_n = 1'b1; h_we = 1'b0; c_req = 1'b1; c_addr = 8'd9;
    @(negedge CLK);
    n_chk++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0)
      $display("FAIL mid_rd_unlock: got c_gnt=%b h_gnt=%b want 1 0", c_gnt, h_gnt); else n_pass++;
    cyc();
    idle();
    n_chk++; if (rst_we_ct !== 0 || mem[50] !== 8'h3C)
      $display("FAIL mid_rd_nowrite: got we_pulses=%0d mem=%h want 0 3c", rst_we_ct, mem[50]); else n_pass++;
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    n_chk++; if (c_gnt_ct !== 16'd0 || h_gnt_ct !== 16'd0)
      $display("FAIL stats_rst: got %0d %0d want 0 0", c_gnt_ct, h_gnt_ct); else n_pass++;
    c_req = 1'b1; c_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c_addr = 8'(200 + i); c_wdata = 8'(i);
      cyc();
    end
    c_req = 1'b0; c_we = 1'b0;
    h_req = 1'b1; h_we = 1'b1;
    for (int i = 0; i < 7; i++) begin
      h_addr = 8'(220 + i); h_wdata = 8'(i);
      cyc();
    end
    idle();
    @(negedge CLK);
    n_chk++; if (c_gnt_ct !== 16'd10 || h_gnt_ct !== 16'd7)
      $display("FAIL stats_count: got %0d %0d want 10 7", c_gnt_ct, h_gnt_ct); else n_pass++;
    cyc();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_core_only();
    test_contention();
    test_host_lock();
    test_lock_release();
    test_reset_mid_read();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
